// File: rtl/csr_pkg.sv
// ============================================================================
//  Module      : csr_pkg
//  Description : Shared CSR address map and mstatus/mcause bit positions for
//                the Hunter_RV32 CSR path. Honours CSR_MCOUNTINHIBIT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package csr_pkg;

    typedef logic [11:0] csr_addr_t;

    localparam csr_addr_t CSR_MSTATUS       = 12'h300;
    localparam csr_addr_t CSR_MIE           = 12'h304;
    localparam csr_addr_t CSR_MTVEC         = 12'h305;
    localparam csr_addr_t CSR_MCOUNTINHIBIT = 12'h320;
    localparam csr_addr_t CSR_MSCRATCH      = 12'h340;
    localparam csr_addr_t CSR_MEPC          = 12'h341;
    localparam csr_addr_t CSR_MCAUSE        = 12'h342;
    localparam csr_addr_t CSR_MTVAL         = 12'h343;
    localparam csr_addr_t CSR_MIP           = 12'h344;
    localparam csr_addr_t CSR_MCYCLE        = 12'hB00;
    localparam csr_addr_t CSR_MCYCLE_ALIAS  = 12'hB01;
    localparam csr_addr_t CSR_MINSTRET      = 12'hB02;
    localparam csr_addr_t CSR_MCYCLEH       = 12'hB80;
    localparam csr_addr_t CSR_MINSTRETH     = 12'hB82;
    localparam csr_addr_t CSR_MHARTID       = 12'hF14;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;
    localparam int MSTATUS_MPP_HI   = 12;
    localparam int MCAUSE_INT_BIT   = 31;

    localparam int MCOUNTINHIBIT_CY_BIT = 0;
    localparam int MCOUNTINHIBIT_IR_BIT = 2;

    // Counter addresses are never forwarded; the forwarding unit uses this.
    function automatic logic csr_is_counter(input csr_addr_t addr);
        return (addr == CSR_MCYCLE) || (addr == CSR_MCYCLE_ALIAS) ||
               (addr == CSR_MINSTRET);
    endfunction

endpackage

`default_nettype wire

// File: rtl/csr_counter64.sv
// ============================================================================
//  Module      : csr_counter64
//  Description : 64-bit free-running counter with increment enable and
//                independent lo/hi write ports; lo overflow carries into hi.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wr_data_i,
    output logic [63:0] count_o
);

    logic [63:0] count_q;
    logic [63:0] count_d;
    logic [63:0] w_count_inc;

    // A written half is replaced; the other half keeps the incremented value,
    // including any carry generated by the old lo half.
    always_comb begin
        w_count_inc = count_q + {63'd0, inc_i};
        count_d     = w_count_inc;
        if (wr_lo_i) begin
            count_d[31:0] = wr_data_i;
        end
        if (wr_hi_i) begin
            count_d[63:32] = wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 64'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/csr_reg_file.sv
// ============================================================================
//  Module      : csr_reg_file
//  Description : Machine-mode CSR storage for Hunter_RV32: EX read port,
//                WB write port, mcycle/minstret, trap entry and mret.
//                Optional mcountinhibit via CSR_MCOUNTINHIBIT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_reg_file
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csrAddr_EX,
    output logic [31:0] csrRdData_EX,
    output logic        csrIllegal_EX,
    input  logic        csrWe_WB,
    input  logic [11:0] csrAddr_WB,
    input  logic [31:0] csrWrData_WB,
    input  logic        instRetire_WB,
    input  logic        trap_WB,
    input  logic [31:0] trapCause_WB,
    input  logic [31:0] trapPc_WB,
    input  logic        mret_WB,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        mie_global_o
);

    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q,      mie_d;
    logic [31:0] mtvec_q,    mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q,     mepc_d;
    logic [31:0] mcause_q,   mcause_d;
    logic [31:0] mtval_q,    mtval_d;

    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;
    logic        w_cycle_inc;
    logic        w_instret_inc;

`ifdef CSR_MCOUNTINHIBIT_EN
    logic        inhibit_cy_q, inhibit_cy_d;
    logic        inhibit_ir_q, inhibit_ir_d;
`endif

    // ------------------------------------------------------------------
    // Next-state: WB write first, then mret, with trap overriding both.
    // ------------------------------------------------------------------
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
`ifdef CSR_MCOUNTINHIBIT_EN
        inhibit_cy_d   = inhibit_cy_q;
        inhibit_ir_d   = inhibit_ir_q;
`endif

        if (csrWe_WB) begin
            case (csrAddr_WB)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = csrWrData_WB[MSTATUS_MIE_BIT];
                    mstatus_mpie_d = csrWrData_WB[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      mie_d      = csrWrData_WB;
                CSR_MTVEC:    mtvec_d    = csrWrData_WB;
                CSR_MSCRATCH: mscratch_d = csrWrData_WB;
                CSR_MEPC:     mepc_d     = csrWrData_WB & ~32'd3;
                CSR_MCAUSE:   mcause_d   = csrWrData_WB;
                CSR_MTVAL:    mtval_d    = csrWrData_WB;
`ifdef CSR_MCOUNTINHIBIT_EN
                CSR_MCOUNTINHIBIT: begin
                    inhibit_cy_d = csrWrData_WB[MCOUNTINHIBIT_CY_BIT];
                    inhibit_ir_d = csrWrData_WB[MCOUNTINHIBIT_IR_BIT];
                end
`endif
                default: ;
            endcase
        end

        if (trap_WB) begin
            mepc_d         = trapPc_WB & ~32'd3;
            mcause_d       = trapCause_WB;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_WB) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 32'd0;
            mtvec_q        <= MTVEC_RESET;
            mscratch_q     <= 32'd0;
            mepc_q         <= 32'd0;
            mcause_q       <= 32'd0;
            mtval_q        <= 32'd0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
        end
    end

`ifdef CSR_MCOUNTINHIBIT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inhibit_cy_q <= 1'b0;
            inhibit_ir_q <= 1'b0;
        end else begin
            inhibit_cy_q <= inhibit_cy_d;
            inhibit_ir_q <= inhibit_ir_d;
        end
    end

    assign w_cycle_inc   = ~inhibit_cy_q;
    assign w_instret_inc = instRetire_WB & ~inhibit_ir_q;
`else
    assign w_cycle_inc   = 1'b1;
    assign w_instret_inc = instRetire_WB;
`endif

    // ------------------------------------------------------------------
    // Counters; 0xB01 is read-only so it has no write enable.
    // ------------------------------------------------------------------
    csr_counter64 u_mcycle (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_i     (w_cycle_inc),
        .wr_lo_i   (csrWe_WB && (csrAddr_WB == CSR_MCYCLE)),
        .wr_hi_i   (csrWe_WB && (csrAddr_WB == CSR_MCYCLEH)),
        .wr_data_i (csrWrData_WB),
        .count_o   (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_i     (w_instret_inc),
        .wr_lo_i   (csrWe_WB && (csrAddr_WB == CSR_MINSTRET)),
        .wr_hi_i   (csrWe_WB && (csrAddr_WB == CSR_MINSTRETH)),
        .wr_data_i (csrWrData_WB),
        .count_o   (w_minstret)
    );

    // ------------------------------------------------------------------
    // EX read port
    // ------------------------------------------------------------------
    always_comb begin
        csrRdData_EX  = 32'd0;
        csrIllegal_EX = 1'b0;
        case (csrAddr_EX)
            CSR_MSTATUS: begin
                csrRdData_EX[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                csrRdData_EX[MSTATUS_MPIE_BIT]              = mstatus_mpie_q;
                csrRdData_EX[MSTATUS_MIE_BIT]               = mstatus_mie_q;
            end
            CSR_MIE:          csrRdData_EX = mie_q;
            CSR_MTVEC:        csrRdData_EX = mtvec_q;
            CSR_MSCRATCH:     csrRdData_EX = mscratch_q;
            CSR_MEPC:         csrRdData_EX = mepc_q;
            CSR_MCAUSE:       csrRdData_EX = mcause_q;
            CSR_MTVAL:        csrRdData_EX = mtval_q;
            CSR_MIP:          csrRdData_EX = 32'd0;
            CSR_MCYCLE:       csrRdData_EX = w_mcycle[31:0];
            CSR_MCYCLE_ALIAS: csrRdData_EX = w_mcycle[31:0];
            CSR_MINSTRET:     csrRdData_EX = w_minstret[31:0];
            CSR_MCYCLEH:      csrRdData_EX = w_mcycle[63:32];
            CSR_MINSTRETH:    csrRdData_EX = w_minstret[63:32];
            CSR_MHARTID:      csrRdData_EX = HART_ID;
`ifdef CSR_MCOUNTINHIBIT_EN
            CSR_MCOUNTINHIBIT: begin
                csrRdData_EX[MCOUNTINHIBIT_CY_BIT] = inhibit_cy_q;
                csrRdData_EX[MCOUNTINHIBIT_IR_BIT] = inhibit_ir_q;
            end
`endif
            default:          csrIllegal_EX = 1'b1;
        endcase
    end

    assign mtvec_o      = mtvec_q;
    assign mepc_o       = mepc_q;
    assign mie_global_o = mstatus_mie_q;

endmodule

`default_nettype wire
